// File: rtl/alu_seq.sv
// alu_seq_pkg : opcode encodings shared by the ALU and anything that drives it.
// alu_seq     : handshaked integer ALU with single-cycle simple ops and
//               iterative (one bit per cycle) unsigned multiply / divide.
//
// Ports (alu_seq):
//   iwClk, iwRst        clock (rising edge), asynchronous active-high reset
//   iwValid / owReady   request handshake; accept when IDLE and iwValid=1
//   iwA, iwB, iwAluOp   operands and opcode, latched at accept
//   iwFlush             synchronous abort of an in-flight or pending op
//   owValid / iwResultReady  result handshake; result held until consumed
//   owResult            registered result
//   owZero, owSign      flags decoded from the owResult register
//   owBusy              iterative op in progress
package alu_seq_pkg;
    localparam logic [5:0] ALU_OP_ADD   = 6'd0;
    localparam logic [5:0] ALU_OP_SUB   = 6'd1;
    localparam logic [5:0] ALU_OP_SLTU  = 6'd2;
    localparam logic [5:0] ALU_OP_SLT   = 6'd3;
    localparam logic [5:0] ALU_OP_AND   = 6'd4;
    localparam logic [5:0] ALU_OP_OR    = 6'd5;
    localparam logic [5:0] ALU_OP_XOR   = 6'd6;
    localparam logic [5:0] ALU_OP_SLL   = 6'd7;
    localparam logic [5:0] ALU_OP_SRL   = 6'd8;
    localparam logic [5:0] ALU_OP_SRA   = 6'd9;
    localparam logic [5:0] ALU_OP_EQ    = 6'd10;
    localparam logic [5:0] ALU_OP_MUL   = 6'd11;
    localparam logic [5:0] ALU_OP_MULHU = 6'd12;
    localparam logic [5:0] ALU_OP_DIVU  = 6'd13;
    localparam logic [5:0] ALU_OP_REMU  = 6'd14;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             iwClk,
    input  logic             iwRst,
    input  logic             iwValid,
    output logic             owReady,
    input  logic [WIDTH-1:0] iwA,
    input  logic [WIDTH-1:0] iwB,
    input  logic [5:0]       iwAluOp,
    input  logic             iwFlush,
    output logic             owValid,
    input  logic             iwResultReady,
    output logic [WIDTH-1:0] owResult,
    output logic             owZero,
    output logic             owSign,
    output logic             owBusy
);
    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [5:0]         op_r;
    logic [WIDTH-1:0]   opnd_r;    // multiplicand (MUL*) or divisor (DIV/REM)
    logic [2*WIDTH-1:0] acc_r;     // {product hi, lo} or {remainder, quotient}
    logic [WIDTH-1:0]   result_r;

    logic               is_iter_s;
    logic               is_mul_s;
    logic               op_mul_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   diff_s;
    logic [2*WIDTH-1:0] step_s;
    logic [WIDTH-1:0]   iter_res_s;

    // Single-cycle operations; unknown opcodes yield zero.
    function automatic logic [WIDTH-1:0] alu_simple(
        input logic [5:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            ALU_OP_ADD:  alu_simple = a + b;
            ALU_OP_SUB:  alu_simple = a - b;
            ALU_OP_SLTU: alu_simple = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_OP_SLT:  alu_simple = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OP_AND:  alu_simple = a & b;
            ALU_OP_OR:   alu_simple = a | b;
            ALU_OP_XOR:  alu_simple = a ^ b;
            ALU_OP_SLL:  alu_simple = a << sh;
            ALU_OP_SRL:  alu_simple = a >> sh;
            ALU_OP_SRA:  alu_simple = WIDTH'($signed(a) >>> sh);
            ALU_OP_EQ:   alu_simple = {{(WIDTH-1){1'b0}}, (a == b)};
            default:     alu_simple = {WIDTH{1'b0}};
        endcase
    endfunction

    // Decode whether the incoming opcode is iterative and which datapath it uses.
    always_comb begin
        is_iter_s = 1'b0;
        is_mul_s  = 1'b0;
        case (iwAluOp)
            ALU_OP_MUL, ALU_OP_MULHU: begin
                is_iter_s = 1'b1;
                is_mul_s  = 1'b1;
            end
            ALU_OP_DIVU, ALU_OP_REMU: begin
                is_iter_s = 1'b1;
                is_mul_s  = 1'b0;
            end
            default: begin
                is_iter_s = 1'b0;
                is_mul_s  = 1'b0;
            end
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        op_mul_s = (op_r == ALU_OP_MUL) || (op_r == ALU_OP_MULHU);
        sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        // Shift the next dividend bit into the partial remainder.
        trial_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        // Any successful subtraction leaves a value below the divisor, so it fits WIDTH bits.
        diff_s   = trial_s[WIDTH-1:0] - opnd_r;
        step_s   = acc_r;
        if (op_mul_s) begin
            if (acc_r[0]) begin
                step_s = {sum_s, acc_r[WIDTH-1:1]};
            end else begin
                step_s = {1'b0, acc_r[2*WIDTH-1:1]};
            end
        end else begin
            // Divisor zero always "fits": quotient becomes all ones, remainder becomes A.
            if (trial_s >= {1'b0, opnd_r}) begin
                step_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Pick the result half from the final step.
    always_comb begin
        case (op_r)
            ALU_OP_MUL:   iter_res_s = step_s[WIDTH-1:0];
            ALU_OP_MULHU: iter_res_s = step_s[2*WIDTH-1:WIDTH];
            ALU_OP_DIVU:  iter_res_s = step_s[WIDTH-1:0];
            ALU_OP_REMU:  iter_res_s = step_s[2*WIDTH-1:WIDTH];
            default:      iter_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CW{1'b0}};
            op_r     <= 6'd0;
            opnd_r   <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else if (iwFlush) begin
            // Abort; the last result stays visible on owResult.
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (iwValid) begin
                        op_r <= iwAluOp;
                        if (is_iter_s) begin
                            opnd_r  <= is_mul_s ? iwA : iwB;
                            acc_r   <= is_mul_s ? {{WIDTH{1'b0}}, iwB} : {{WIDTH{1'b0}}, iwA};
                            cnt_r   <= CNT_INIT;
                            state_r <= S_BUSY;
                        end else begin
                            result_r <= alu_simple(iwAluOp, iwA, iwB);
                            state_r  <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_r <= iter_res_s;
                        state_r  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (iwResultReady) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign owReady  = (state_r == S_IDLE);
    assign owBusy   = (state_r == S_BUSY);
    assign owValid  = (state_r == S_DONE);
    assign owResult = result_r;
    assign owZero   = (result_r == {WIDTH{1'b0}});
    assign owSign   = result_r[WIDTH-1];
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit and an 8-bit instance.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        va, rr, fl;
    logic [31:0] a, b;
    logic [5:0]  op;
    logic        owReady, owValid, owZero, owSign, owBusy;
    logic [31:0] owResult;

    logic        va8;
    logic [7:0]  a8, b8;
    logic [5:0]  op8;
    logic        rdy8, vld8, zero8, sign8, busy8;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;
    exp_t q32[$];
    exp_t q8[$];

    alu_seq #(.WIDTH(32)) dut (
        .iwClk(clk), .iwRst(rst), .iwValid(va), .owReady(owReady),
        .iwA(a), .iwB(b), .iwAluOp(op), .iwFlush(fl), .owValid(owValid),
        .iwResultReady(rr), .owResult(owResult), .owZero(owZero),
        .owSign(owSign), .owBusy(owBusy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .iwClk(clk), .iwRst(rst), .iwValid(va8), .owReady(rdy8),
        .iwA(a8), .iwB(b8), .iwAluOp(op8), .iwFlush(1'b0), .owValid(vld8),
        .iwResultReady(1'b1), .owResult(res8), .owZero(zero8),
        .owSign(sign8), .owBusy(busy8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    // Monitor for the 32-bit instance: pops on every consumed result.
    always @(negedge clk) begin
        if (!rst && owValid && rr) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result32 actual=0x%h required=none", owResult);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk({e.name, "_res"}, owResult, e.val);
                chk({e.name, "_zero"}, 32'(owZero), 32'(e.val == 32'd0));
                chk({e.name, "_sign"}, 32'(owSign), 32'(e.val[31]));
            end
        end
    end

    // Monitor for the 8-bit instance (consumer always ready).
    always @(negedge clk) begin
        if (!rst && vld8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result8 actual=0x%h required=none", res8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk({e.name, "_res"}, 32'(res8), e.val);
                chk({e.name, "_sign"}, 32'(sign8), 32'(e.val[7]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input bit push, input string name);
        int t = 0;
        while (!owReady && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_ready_wait"}, 32'(owReady), 32'd1);
        if (push) q32.push_back('{val: e, name: name});
        op = o; a = x; b = y; va = 1'b1;
        @(posedge clk); #1;
        va = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = ALU_OP_SUB;
    endtask

    // Issue, then measure edges from accept to owValid and busy/ready behaviour.
    task automatic do_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat, input string name);
        int n = 0, busy = 0, rdyhi = 0;
        issue(o, x, y, e, 1'b1, name);
        while (!owValid && n < 100) begin
            if (owBusy) busy++;
            if (owReady) rdyhi++;
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        if (lat > 0) begin
            chk({name, "_busy"}, 32'(busy), 32'(lat));
            chk({name, "_rdy_low"}, 32'(rdyhi), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_op8(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] e, input int lat, input string name);
        int n = 0;
        chk({name, "_ready"}, 32'(rdy8), 32'd1);
        q8.push_back('{val: {24'd0, e}, name: name});
        op8 = o; a8 = x; b8 = y; va8 = 1'b1;
        @(posedge clk); #1;
        va8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        while (!vld8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        rst = 1'b1; va = 1'b0; rr = 1'b1; fl = 1'b0;
        a = 32'd0; b = 32'd0; op = ALU_OP_ADD;
        va8 = 1'b0; a8 = 8'd0; b8 = 8'd0; op8 = ALU_OP_ADD;
        #2;
        chk("rst_ready", 32'(owReady), 32'd1);
        chk("rst_valid", 32'(owValid), 32'd0);
        chk("rst_busy", 32'(owBusy), 32'd0);
        chk("rst_result", owResult, 32'd0);
        chk("rst_zero", 32'(owZero), 32'd1);
        chk("rst_sign", 32'(owSign), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(ALU_OP_ADD,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0, "add_wrap");
        do_op(ALU_OP_SUB,  32'd5, 32'd5, 32'd0, 0, "sub_zero");
        do_op(ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 0, "slt");
        do_op(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, "sltu");
        do_op(ALU_OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 0, "sra");
        do_op(ALU_OP_SRL,  32'h8000_0000, 32'h24, 32'h0800_0000, 0, "srl");
        do_op(ALU_OP_SLL,  32'd1, 32'h21, 32'd2, 0, "sll");
        do_op(ALU_OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0, "and");
        do_op(ALU_OP_OR,   32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 0, "or");
        do_op(ALU_OP_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0, "xor");
        do_op(ALU_OP_EQ,   32'd7, 32'd7, 32'd1, 0, "eq");
        do_op(6'd63,       32'd7, 32'd9, 32'd0, 0, "unknown");

        do_op(ALU_OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, "mul");
        do_op(ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu");
        do_op(ALU_OP_MUL,   32'd12345, 32'd678, 32'd8369910, 32, "mul_small");
        do_op(ALU_OP_DIVU,  32'd100, 32'd7, 32'd14, 32, "divu");
        do_op(ALU_OP_REMU,  32'd100, 32'd7, 32'd2, 32, "remu");
        do_op(ALU_OP_DIVU,  32'd123, 32'd0, 32'hFFFF_FFFF, 32, "divu_by0");
        do_op(ALU_OP_REMU,  32'd123, 32'd0, 32'd123, 32, "remu_by0");
        do_op(ALU_OP_DIVU,  32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32, "divu_big");

        do_op8(ALU_OP_MUL,   8'hFF, 8'hFF, 8'h01, 8, "w8_mul");
        do_op8(ALU_OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 8, "w8_mulhu");
        do_op8(ALU_OP_DIVU,  8'd200, 8'd9, 8'd22, 8, "w8_divu");
        do_op8(ALU_OP_REMU,  8'd200, 8'd9, 8'd2, 8, "w8_remu");

        // Backpressure: result held, new requests ignored.
        rr = 1'b0;
        issue(ALU_OP_ADD, 32'd10, 32'd20, 32'd30, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            va = 1'b1; op = ALU_OP_SUB; a = 32'd1; b = 32'd2;
            chk("bp_valid", 32'(owValid), 32'd1);
            chk("bp_hold", owResult, 32'd30);
            @(posedge clk); #1;
        end
        va = 1'b0;
        chk("bp_valid_end", 32'(owValid), 32'd1);
        rr = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 32'(owReady), 32'd1);
        chk("bp_idle_valid", 32'(owValid), 32'd0);
        do_op(ALU_OP_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 0, "bp_next");

        // Flush during BUSY cycle 10 of a DIVU.
        issue(ALU_OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, "flush");
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("flush_busy_before", 32'(owBusy), 32'd1);
        fl = 1'b1;
        @(posedge clk); #1;
        fl = 1'b0;
        chk("flush_ready", 32'(owReady), 32'd1);
        chk("flush_busy", 32'(owBusy), 32'd0);
        chk("flush_keep_result", owResult, 32'h0000_00F0);
        seen = 0;
        repeat (40) begin
            if (owValid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a MUL.
        issue(ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, "rstmid");
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ready", 32'(owReady), 32'd1);
        chk("rstmid_valid", 32'(owValid), 32'd0);
        chk("rstmid_busy", 32'(owBusy), 32'd0);
        chk("rstmid_result", owResult, 32'd0);
        chk("rstmid_zero", 32'(owZero), 32'd1);
        chk("rstmid_sign", 32'(owSign), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(ALU_OP_ADD, 32'd40, 32'd2, 32'd42, 0, "after_rst");

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("q32_drained", 32'(q32.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
